// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and a selectable
// first-word-fall-through read mode.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset (clears pointers/count, not memory)
//   cs           chip select; gates every read, write and error pulse
//   wr_en        write request
//   rd_en        read request (pop/acknowledge in FWFT mode)
//   data_in      write data
//   data_out     read data
//   rd_valid     data_out holds a valid word
//   count        occupancy, 0..fifo_depth
//   empty/full   count == 0 / count == fifo_depth
//   almost_empty count <= ae_thresh
//   almost_full  count >= af_thresh
//   overflow     one-cycle pulse: a write was rejected
//   underflow    one-cycle pulse: a read was rejected
module sync_fifo_param #(
   parameter int unsigned data_width = 32,
   parameter int unsigned fifo_depth = 8,
   parameter int unsigned fwft       = 0,
   parameter int unsigned af_thresh  = fifo_depth - 2,
   parameter int unsigned ae_thresh  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cs,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic [data_width-1:0]         data_in,
   output logic [data_width-1:0]         data_out,
   output logic                          rd_valid,
   output logic [$clog2(fifo_depth):0]   count,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned aw = $clog2(fifo_depth);
   localparam int unsigned cw = aw + 1;

   localparam logic [cw-1:0] af_lvl   = cw'(af_thresh);
   localparam logic [cw-1:0] ae_lvl   = cw'(ae_thresh);
   localparam logic [cw-1:0] full_lvl = cw'(fifo_depth);

   logic [data_width-1:0] mem [fifo_depth];

   logic [aw-1:0] wr_ptr_q, wr_ptr_d;
   logic [aw-1:0] rd_ptr_q, rd_ptr_d;
   logic [cw-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic rd_acc;
   logic wr_acc;

   // Flags come straight from the registered count: no input-to-flag paths.
   assign empty        = (count_q == '0);
   assign full         = (count_q == full_lvl);
   assign almost_empty = (count_q <= ae_lvl);
   assign almost_full  = (count_q >= af_lvl);

   // A full FIFO may still take a write when a read frees a slot this cycle;
   // an empty FIFO never serves a read, even alongside a write.
   assign rd_acc = cs & rd_en & ~empty;
   assign wr_acc = cs & wr_en & (~full | rd_acc);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = cs & wr_en & full & ~rd_acc;
      underflow_d = cs & rd_en & empty;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + aw'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + aw'(1);
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + cw'(1);
         2'b01:   count_d = count_q - cw'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never cleared; reset only blocks the write for that cycle.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   if (fwft == 0) begin : g_std
      logic [data_width-1:0] dout_q;
      logic                  valid_q;

      // mem is read before the same-edge write lands, so a full-FIFO
      // read/write to one address returns the old word.
      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= mem[rd_ptr_q];
            end
         end
      end

      assign data_out = dout_q;
      assign rd_valid = valid_q;
   end else begin : g_fwft
      // Head of queue is always presented; rd_en only pops it.
      assign data_out = mem[rd_ptr_q];
      assign rd_valid = ~empty;
   end

endmodule
